sticky_shift_sequencer: RTL and testbench
=========================================

# sticky_shift_sequencer

Multi-cycle right-shifter with sticky-bit generation for the float rounding path. It shifts one operand right and ORs every shifted-out bit into a sticky flag. The sticky reduction is done CHUNK bits per cycle through a single bounded part-select-OR slice, which replaces one IN_WIDTH-wide OR tree. The block sits between alignment and rounding and uses a valid/ready handshake on both sides.

## Interface
- IN_WIDTH, 32: operand width in bits.
- CHUNK, 8: bits OR-reduced per SCAN cycle; 1 ≤ CHUNK ≤ IN_WIDTH.
- SHIFT_WIDTH, 6: shift-amount width; must be able to represent IN_WIDTH.
- clock  input  1  single clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high; sampled on the clock edge.
- inValid  input  1  operand and shift are valid.
- inReady  output  1  block can accept; high only in IDLE.
- inData  input  IN_WIDTH  operand.
- inShift  input  SHIFT_WIDTH  right-shift amount, unsigned.
- outValid  output  1  result is valid; high only in DONE.
- outReady  input  1  consumer accepts the result.
- outData  output  IN_WIDTH  inData >> shift.
- outSticky  output  1  OR of all bits shifted out.

## Operation
- States:
  - IDLE: inReady=1.
  - SCAN: one chunk reduced per cycle.
  - DONE: outValid=1; outData and outSticky held.
- Accept: a transfer occurs on any edge in IDLE with inValid=1. On that edge:
  - latch data=inData;
  - latch sh=min(inShift, IN_WIDTH) (saturating);
  - clear idx=0 and sticky=0.
- IDLE exit on accept: if sh==0, go to DONE; otherwise go to SCAN.
- SCAN, each cycle:
  - sticky |= OR of data[min(idx+CHUNK, sh)-1 : idx];
  - idx += CHUNK.
  - Bits at or above sh are never included. Slice bounds are clamped so no out-of-range index is formed.
  - If idx+CHUNK ≥ sh, go to DONE; otherwise stay in SCAN.
- DONE:
  - outData = sh==IN_WIDTH ? 0 : data >> sh, registered on entry to DONE.
  - outSticky = final sticky.
  - Return to IDLE on an edge with outReady=1.
- Non-overlapping: no new operand is accepted until the result has transferred. inValid outside IDLE is ignored and has no side effect.
- Outputs in DONE stay stable under backpressure of any length.
- Reset (at any state, including mid-SCAN or mid-DONE):
  - state goes to IDLE; the in-flight operation is discarded;
  - outValid=0, outData=0, outSticky=0, idx=0;
  - inReady=1 in the first cycle after the reset edge.

## Timing
- inReady and outValid are decoded directly from the state register. Neither has a combinational path from any input.
- Accept edge at cycle 0. SCAN occupies cycles 1..N, where N=ceil(sh/CHUNK). outValid rises in cycle N+1.
- sh==0: outValid rises in cycle 1.
- Throughput: one operation per N+2 cycles when outReady is held high.
- Saturated shift (inShift ≥ IN_WIDTH): N=ceil(IN_WIDTH/CHUNK), outData=0, outSticky=|inData.

## Configuration
- STICKY_SHIFT_EARLY_EXIT_EN defined:
  - SCAN also exits to DONE on the first edge where the updated sticky is 1. Remaining chunks are skipped, since they cannot change the result.
  - outData is unaffected.
  - Latency varies with data: 1..N SCAN cycles.
- Not defined: SCAN always runs exactly N cycles, so latency depends only on sh.

## Test plan
All cases use IN_WIDTH=32, CHUNK=8.
- inData=0x0000_0100, inShift=8 -> 1 SCAN cycle; outData=0x0000_0001, outSticky=0, outValid in cycle 2.
- inData=0x0000_0081, inShift=1 -> outData=0x0000_0040, outSticky=1; bit 7 is excluded from sticky because it is ≥ sh.
- inData=0x0000_0001, inShift=40 -> saturates to 32; outData=0, outSticky=1. SCAN lasts 4 cycles without the macro and 1 cycle with STICKY_SHIFT_EARLY_EXIT_EN.
- inData=0xDEAD_BEEF, inShift=0 -> outData=0xDEAD_BEEF, outSticky=0, outValid in cycle 1, no SCAN cycles.
- Result in DONE with outReady=0 for 5 cycles while inValid=1 with new data -> outData/outSticky unchanged and inReady=0 throughout. After outReady=1, the next operand is accepted in the first IDLE cycle.
- reset asserted in the 2nd SCAN cycle of inShift=32 -> next cycle: IDLE, inReady=1, outValid=0, outData=0, outSticky=0. A following operation computes correctly, with no stale sticky.

Source files
------------

// File: rtl/sticky_shift_sequencer.sv
// Multi-cycle right shifter with sticky-bit reduction, CHUNK bits per SCAN cycle.
// Optional build macro STICKY_SHIFT_EARLY_EXIT_EN: leave SCAN as soon as sticky is set.
module sticky_shift_sequencer #(
  parameter int IN_WIDTH    = 32,
  parameter int CHUNK       = 8,
  parameter int SHIFT_WIDTH = 6
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   inValid,
  output logic                   inReady,
  input  logic [IN_WIDTH-1:0]    inData,
  input  logic [SHIFT_WIDTH-1:0] inShift,
  output logic                   outValid,
  input  logic                   outReady,
  output logic [IN_WIDTH-1:0]    outData,
  output logic                   outSticky
);

  // Index must hold idx+CHUNK without wrapping, even past the last chunk.
  localparam int IDX_W = $clog2(IN_WIDTH + CHUNK + 1);
  localparam logic [SHIFT_WIDTH-1:0] SH_MAX = SHIFT_WIDTH'(IN_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } state_t;

  state_t                 r_state;
  logic [IN_WIDTH-1:0]    r_data;
  logic [SHIFT_WIDTH-1:0] r_sh;
  logic [IDX_W-1:0]       r_idx;
  logic                   r_sticky;
  logic [IN_WIDTH-1:0]    r_out_data;
  logic                   r_out_sticky;

  logic [SHIFT_WIDTH-1:0] w_sh_sat;
  logic [IDX_W-1:0]       w_remaining;
  logic [CHUNK-1:0]       w_window;
  logic                   w_chunk_or;
  logic                   w_sticky_next;
  logic                   w_last_chunk;
  logic                   w_scan_exit;
  logic [IN_WIDTH-1:0]    w_shifted;

  assign w_sh_sat     = (inShift > SH_MAX) ? SH_MAX : inShift;
  assign w_remaining  = IDX_W'(r_sh) - r_idx;
  assign w_last_chunk = (r_idx + IDX_W'(CHUNK)) >= IDX_W'(r_sh);
  // Shifting the operand down first keeps the slice index inside [CHUNK-1:0].
  assign w_window     = CHUNK'(r_data >> r_idx);
  assign w_shifted    = (r_sh == SH_MAX) ? '0 : (r_data >> r_sh);

  // NOTE: every always_comb output gets a default before the loop, so no latch is inferred.
  always_comb begin
    w_chunk_or = 1'b0;
    for (int j = 0; j < CHUNK; j++) begin
      if (IDX_W'(j) < w_remaining) w_chunk_or = w_chunk_or | w_window[j];
    end
  end

  assign w_sticky_next = r_sticky | w_chunk_or;

`ifdef STICKY_SHIFT_EARLY_EXIT_EN
  assign w_scan_exit = w_last_chunk | w_sticky_next;
`else
  assign w_scan_exit = w_last_chunk;
`endif

  // NOTE: state uses non-blocking assignments only; reset clears the whole datapath,
  // so a discarded operation cannot leak a stale sticky into the next one.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_data       <= '0;
      r_sh         <= '0;
      r_idx        <= '0;
      r_sticky     <= 1'b0;
      r_out_data   <= '0;
      r_out_sticky <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (inValid) begin
            r_data   <= inData;
            r_sh     <= w_sh_sat;
            r_idx    <= '0;
            r_sticky <= 1'b0;
            if (w_sh_sat == '0) begin
              r_out_data   <= inData;
              r_out_sticky <= 1'b0;
              r_state      <= S_DONE;
            end else begin
              r_state <= S_SCAN;
            end
          end
        end
        S_SCAN: begin
          r_sticky <= w_sticky_next;
          r_idx    <= r_idx + IDX_W'(CHUNK);
          if (w_scan_exit) begin
            r_out_data   <= w_shifted;
            r_out_sticky <= w_sticky_next;
            r_state      <= S_DONE;
          end
        end
        S_DONE: begin
          if (outReady) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign inReady   = (r_state == S_IDLE);
  assign outValid  = (r_state == S_DONE);
  assign outData   = r_out_data;
  assign outSticky = r_out_sticky;

endmodule

// File: tb/tb_sticky_shift_sequencer.sv
// Self-checking bench for sticky_shift_sequencer: directed cases plus random operands
// compared against an arithmetic reference model.
module tb_sticky_shift_sequencer;

  localparam int W  = 32;
  localparam int C  = 8;
  localparam int SW = 6;

  logic          clock = 1'b0;
  logic          reset;
  logic          inValid;
  logic          inReady;
  logic [W-1:0]  inData;
  logic [SW-1:0] inShift;
  logic          outValid;
  logic          outReady;
  logic [W-1:0]  outData;
  logic          outSticky;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  sticky_shift_sequencer #(.IN_WIDTH(W), .CHUNK(C), .SHIFT_WIDTH(SW)) dut (
    .clock     (clock),
    .reset     (reset),
    .inValid   (inValid),
    .inReady   (inReady),
    .inData    (inData),
    .inShift   (inShift),
    .outValid  (outValid),
    .outReady  (outReady),
    .outData   (outData),
    .outSticky (outSticky)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
  endtask

  // Reference model: plain arithmetic on the saturated shift amount.
  function automatic int model_sh(input int s);
    return (s > W) ? W : s;
  endfunction

  function automatic logic [31:0] model_data(input logic [31:0] d, input int sh);
    return (sh >= W) ? 32'd0 : (d >> sh);
  endfunction

  function automatic logic model_sticky(input logic [31:0] d, input int sh);
    logic [63:0] mask;
    mask = (64'd1 << sh) - 64'd1;
    return (({32'd0, d} & mask) != 64'd0);
  endfunction

  // Cycles from the accept edge to the first cycle with outValid high.
  function automatic int model_latency(input logic [31:0] d, input int sh);
    int n;
    n = (sh + C - 1) / C;
    if (sh == 0) return 1;
`ifdef STICKY_SHIFT_EARLY_EXIT_EN
    for (int k = 1; k <= n; k++) begin
      int top;
      top = (k * C < sh) ? k * C : sh;
      if (model_sticky(d, top)) return k + 1;
    end
`endif
    return n + 1;
  endfunction

  task automatic do_op(input logic [31:0] d, input int s, input int bp);
    int          sh;
    int          cyc;
    bit          done;
    logic [31:0] exp_data;
    logic        exp_sticky;
    sh         = model_sh(s);
    exp_data   = model_data(d, sh);
    exp_sticky = model_sticky(d, sh);

    @(negedge clock);
    check("in_ready_idle", inReady, 1);
    check("out_valid_idle", outValid, 0);
    inValid = 1'b1;
    inData  = d;
    inShift = SW'(s);
    @(posedge clock);
    #1;
    inValid = 1'b0;

    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 64) begin
      @(negedge clock);
      cyc++;
      if (outValid) begin
        done = 1'b1;
      end else begin
        check("in_ready_busy", inReady, 0);
        inValid = 1'($urandom_range(0, 1));
        inData  = $urandom;
        inShift = SW'($urandom);
      end
    end
    check("latency", cyc, model_latency(d, sh));
    check("out_data", outData, exp_data);
    check("out_sticky", outSticky, exp_sticky);
    check("in_ready_done", inReady, 0);

    for (int i = 0; i < bp; i++) begin
      outReady = 1'b0;
      inValid  = 1'b1;
      inData   = $urandom;
      inShift  = SW'($urandom);
      @(negedge clock);
      check("bp_out_valid", outValid, 1);
      check("bp_in_ready", inReady, 0);
      check("bp_out_data", outData, exp_data);
      check("bp_out_sticky", outSticky, exp_sticky);
    end

    outReady = 1'b1;
    @(posedge clock);
    #1;
    outReady = 1'b0;
    inValid  = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    inValid  = 1'b0;
    outReady = 1'b0;
    inData   = '0;
    inShift  = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("rst_in_ready", inReady, 1);
    check("rst_out_valid", outValid, 0);
    check("rst_out_data", outData, 0);
    check("rst_out_sticky", outSticky, 0);

    do_op(32'h0000_0100, 8, 0);
    do_op(32'h0000_0081, 1, 0);
    do_op(32'h0000_0001, 40, 0);
    do_op(32'hDEAD_BEEF, 0, 0);
    do_op(32'h8000_0000, 31, 0);
    do_op(32'h1234_5678, 20, 5);
    do_op(32'hCAFE_F00D, 32, 0);

    // Reset in the second SCAN cycle of a full-width shift.
    @(negedge clock);
    inValid = 1'b1;
    inData  = 32'hFFFF_FFFF;
    inShift = 6'd32;
    @(posedge clock);
    #1;
    inValid = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("midscan_rst_in_ready", inReady, 1);
    check("midscan_rst_out_valid", outValid, 0);
    check("midscan_rst_out_data", outData, 0);
    check("midscan_rst_out_sticky", outSticky, 0);
    do_op(32'h0000_0100, 8, 0);

    for (int n = 0; n < 40; n++) begin
      logic [31:0] d;
      case ($urandom_range(0, 3))
        0:       d = 32'd1 << $urandom_range(0, 31);
        1:       d = 32'hFFFF_FFFF;
        default: d = $urandom;
      endcase
      do_op(d, int'($urandom_range(0, 63)), int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
